// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the data SRAM load/store controller
package mem_pkg;
  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_BYTE = 2'b01;
  localparam logic [1:0] SEL_HALF = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_DONE
  } state_e;

  localparam logic       STROBE_ON  = 1'b0;
  localparam logic       STROBE_OFF = 1'b1;
  localparam logic [3:0] BE_ALL     = 4'b0000;
  localparam logic [3:0] BE_NONE    = 4'b1111;
endpackage

// File: rtl/data_sram_ctrl_if.sv
// rtl/data_sram_ctrl_if.sv - MEM-stage request/response bus of the data SRAM controller
interface data_sram_ctrl_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_sel;
  logic        req_signed;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  modport master (
    output req_read, req_write, req_addr, req_wdata, req_sel, req_signed,
    input  rdata, stall, err
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, req_sel, req_signed,
    output rdata, stall, err
  );
endinterface

// File: rtl/sram_lane_align.sv
// rtl/sram_lane_align.sv - byte-lane enables, store replication, load extraction, alignment check
module sram_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  sel,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign half_lane = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_lane = rword[7:0];
    case (addr_lo)
      2'd1:    byte_lane = rword[15:8];
      2'd2:    byte_lane = rword[23:16];
      2'd3:    byte_lane = rword[31:24];
      default: byte_lane = rword[7:0];
    endcase
  end

  always_comb begin
    be_n       = BE_NONE;
    wdata_rep  = wdata;
    rdata_ext  = rword;
    misaligned = 1'b0;
    case (sel)
      SEL_WORD: begin
        be_n       = BE_ALL;
        misaligned = (addr_lo != 2'd0);
      end
      SEL_BYTE: begin
        case (addr_lo)
          2'd0:    be_n = 4'b1110;
          2'd1:    be_n = 4'b1101;
          2'd2:    be_n = 4'b1011;
          default: be_n = 4'b0111;
        endcase
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      end
      SEL_HALF: begin
        be_n       = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & half_lane[15]}}, half_lane};
        misaligned = addr_lo[0];
      end
      default: misaligned = 1'b1;
    endcase
  end
endmodule

// File: rtl/data_sram_ctrl.sv
// rtl/data_sram_ctrl.sv - multi-cycle load/store sequencer for the asynchronous data SRAM
module data_sram_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_sram_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [31:0]       ram_data_o,
  output logic              ram_data_oe,
  input  logic [31:0]       ram_data_i
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic [1:0]         sel_q, sel_d;
  logic               signed_q, signed_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [3:0]         be_n_q, be_n_d;
  logic               ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [31:0]        data_o_q, data_o_d;
  logic               data_oe_q, data_oe_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               idle, accept, reject;
  logic [3:0]         al_be_n;
  logic [31:0]        al_wdata, al_rdata;
  logic               al_misaligned;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  // In IDLE the aligner judges the incoming request; afterwards it works on the latched one.
  assign idle = (state_q == ST_IDLE);

  sram_lane_align u_align (
    .addr_lo    (idle ? bus.req_addr[1:0] : addr_lo_q),
    .sel        (idle ? bus.req_sel : sel_q),
    .sign_ext   (idle ? bus.req_signed : signed_q),
    .wdata      (bus.req_wdata),
    .rword      (ram_data_i),
    .be_n       (al_be_n),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned)
  );

  assign accept = idle && (bus.req_read ^ bus.req_write) && !al_misaligned;
  assign reject = idle && (bus.req_read | bus.req_write) && !accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_lo_d  = addr_lo_q;
    sel_d      = sel_q;
    signed_d   = signed_q;
    ram_addr_d = ram_addr_q;
    be_n_d     = be_n_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    data_o_d   = data_o_q;
    data_oe_d  = data_oe_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_lo_d  = bus.req_addr[1:0];
          sel_d      = bus.req_sel;
          signed_d   = bus.req_signed;
          ram_addr_d = bus.req_addr[ADDR_W+1:2];
          ce_n_d     = STROBE_ON;
          cnt_d      = CNT_LAST;
          if (bus.req_read) begin
            be_n_d    = BE_ALL;
            oe_n_d    = STROBE_ON;
            data_oe_d = 1'b0;
            state_d   = ST_RD;
          end else begin
            be_n_d    = al_be_n;
            data_o_d  = al_wdata;
            data_oe_d = 1'b1;
            state_d   = ST_WR_SETUP;
          end
        end else if (reject) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          rdata_d = al_rdata;
          ce_n_d  = STROBE_OFF;
          oe_n_d  = STROBE_OFF;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        we_n_d  = STROBE_ON;
        cnt_d   = CNT_LAST;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          we_n_d  = STROBE_OFF;
          ce_n_d  = STROBE_OFF;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Lanes stay driven through DONE so the write has hold time after we_n rises.
        be_n_d  = BE_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_lo_q  <= 2'd0;
      sel_q      <= SEL_WORD;
      signed_q   <= 1'b0;
      ram_addr_q <= '0;
      be_n_q     <= BE_NONE;
      ce_n_q     <= STROBE_OFF;
      oe_n_q     <= STROBE_OFF;
      we_n_q     <= STROBE_OFF;
      data_o_q   <= 32'h0;
      data_oe_q  <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_lo_q  <= addr_lo_d;
      sel_q      <= sel_d;
      signed_q   <= signed_d;
      ram_addr_q <= ram_addr_d;
      be_n_q     <= be_n_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      data_o_q   <= data_o_d;
      data_oe_q  <= data_oe_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.stall = !rst && (accept || (state_q inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE}));
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

  assign ram_addr    = ram_addr_q;
  assign ram_be_n    = be_n_q;
  assign ram_ce_n    = ce_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign ram_data_o  = data_o_q;
  assign ram_data_oe = data_oe_q;
endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb/tb_data_sram_ctrl.sv - randomized bench for data_sram_ctrl against a byte-level memory model
module tb_data_sram_ctrl;
  import mem_pkg::*;

  localparam int W = 3;

  logic        clk;
  logic        rst;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  logic [31:0] ram_data_o;
  logic        ram_data_oe;
  logic [31:0] ram_data_i;

  data_sram_ctrl_if bus_if ();

  data_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .ram_addr    (ram_addr),
    .ram_be_n    (ram_be_n),
    .ram_ce_n    (ram_ce_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n),
    .ram_data_o  (ram_data_o),
    .ram_data_oe (ram_data_oe),
    .ram_data_i  (ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
  logic [31:0] model_rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be_n);
    logic [31:0] r = old;
    for (int l = 0; l < 4; l++)
      if (!be_n[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
    end else if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
      sram[ram_addr[7:0]] <= merge(sram[ram_addr[7:0]], ram_data_o, ram_be_n);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic is_misaligned(input logic [1:0] sel, input logic [31:0] addr);
    return (sel == 2'd3) || (sel == SEL_WORD && addr % 4 != 0) || (sel == SEL_HALF && addr % 2 != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sel, input logic [31:0] addr);
    logic [1:0] off = addr[1:0];
    if (sel == SEL_BYTE) return 4'hF ^ (4'h1 << off);
    if (sel == SEL_HALF) return 4'hF ^ (4'h3 << off);
    return 4'h0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sel, input logic [31:0] d);
    if (sel == SEL_BYTE) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (sel == SEL_HALF) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] sel, input logic sgn);
    int          sh = 8 * int'(addr % 4);
    logic [31:0] v  = word >> sh;
    if (sel == SEL_BYTE) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sel == SEL_HALF) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with the request dropped.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] sel, input logic sgn,
                           input string tag);
    logic        rej   = (rd && wr) || is_misaligned(sel, addr);
    logic [3:0]  e_be  = model_be(sel, addr);
    logic [31:0] e_wd  = model_wdata(sel, wdata);
    logic [19:0] e_ra  = addr[21:2];
    int          total = 0, stalls = 0, we_low = 0;
    logic        done = 1'b0, overlap = 1'b0, bad_pulse = 1'b0;
    bus_if.req_read   = rd;
    bus_if.req_write  = wr;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    bus_if.req_sel    = sel;
    bus_if.req_signed = sgn;
    if (rej) begin
      @(negedge clk);
      check({tag, "_rej_stall"}, {31'h0, bus_if.stall}, 32'h0);
      check({tag, "_rej_ce_n"}, {31'h0, ram_ce_n}, 32'h1);
      @(posedge clk); #1;
      bus_if.req_read  = 1'b0;
      bus_if.req_write = 1'b0;
      model_rdata = 32'h0;
      @(negedge clk);
      check({tag, "_rej_err"}, {31'h0, bus_if.err}, 32'h1);
      check({tag, "_rej_rdata"}, bus_if.rdata, model_rdata);
      @(negedge clk);
      check({tag, "_rej_err_end"}, {31'h0, bus_if.err}, 32'h0);
      @(posedge clk); #1;
      return;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      total++;
      if (c == 0) check({tag, "_rdata_hold"}, bus_if.rdata, model_rdata);
      if (!ram_oe_n && !ram_we_n) overlap = 1'b1;
      if (!ram_we_n) begin
        we_low++;
        if (ram_be_n !== e_be || ram_data_o !== e_wd || ram_ce_n || ram_addr !== e_ra)
          bad_pulse = 1'b1;
      end
      if (bus_if.stall) stalls++;
      else done = 1'b1;
      if (!done) @(posedge clk);
    end
    check({tag, "_finished"}, {31'h0, done}, 32'h1);
    check({tag, "_strobe_overlap"}, {31'h0, overlap}, 32'h0);
    check({tag, "_idle_strobes"}, {29'h0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    check({tag, "_ram_addr"}, {12'h0, ram_addr}, {12'h0, e_ra});
    if (rd) begin
      model_rdata = model_load(ref_mem[addr[9:2]], addr, sel, sgn);
      check({tag, "_latency"}, total, 2 + W);
      check({tag, "_stall_cycles"}, stalls, 1 + W);
      check({tag, "_rdata"}, bus_if.rdata, model_rdata);
    end else begin
      ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], e_wd, e_be);
      check({tag, "_latency"}, total, 3 + W);
      check({tag, "_stall_cycles"}, stalls, 2 + W);
      check({tag, "_we_low"}, we_low, W);
      check({tag, "_pulse_lanes"}, {31'h0, bad_pulse}, 32'h0);
      check({tag, "_hold_be_n"}, {28'h0, ram_be_n}, {28'h0, e_be});
      check({tag, "_hold_data"}, ram_data_o, e_wd);
      check({tag, "_hold_oe"}, {31'h0, ram_data_oe}, 32'h1);
    end
    @(posedge clk); #1;
    bus_if.req_read  = 1'b0;
    bus_if.req_write = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    logic        rd;
    int          kind;
    logic        hit;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    model_rdata       = 32'h0;
    rst               = 1'b1;
    bus_if.req_read   = 1'b1;
    bus_if.req_write  = 1'b0;
    bus_if.req_addr   = 32'h0;
    bus_if.req_wdata  = 32'h0;
    bus_if.req_sel    = SEL_WORD;
    bus_if.req_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {29'h0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    check("rst_be_n", {28'h0, ram_be_n}, 32'hF);
    check("rst_data_oe", {31'h0, ram_data_oe}, 32'h0);
    check("rst_ram_addr", {12'h0, ram_addr}, 32'h0);
    check("rst_data_o", ram_data_o, 32'h0);
    check("rst_rdata", bus_if.rdata, 32'h0);
    check("rst_err", {31'h0, bus_if.err}, 32'h0);
    check("rst_stall", {31'h0, bus_if.stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.req_read = 1'b0;

    do_access(0, 1, 32'h10, 32'hDEAD_BEEF, SEL_WORD, 0, "st_w10");
    do_access(1, 0, 32'h10, 32'h0, SEL_WORD, 0, "ld_w10");
    check("ld_w10_const", bus_if.rdata, 32'hDEAD_BEEF);
    do_access(0, 1, 32'h10, 32'h80FF_0000, SEL_WORD, 0, "st_w10b");
    do_access(1, 0, 32'h13, 32'h0, SEL_BYTE, 1, "ld_sb13");
    check("ld_sb13_const", bus_if.rdata, 32'hFFFF_FF80);
    do_access(1, 0, 32'h13, 32'h0, SEL_BYTE, 0, "ld_ub13");
    check("ld_ub13_const", bus_if.rdata, 32'h0000_0080);
    do_access(0, 1, 32'h22, 32'h0000_1234, SEL_HALF, 0, "st_h22");
    do_access(1, 0, 32'h20, 32'h0, SEL_WORD, 0, "ld_w20");
    check("ld_w20_const", bus_if.rdata, 32'h1234_0000);
    do_access(1, 0, 32'h6, 32'h0, SEL_WORD, 0, "ld_mis6");
    do_access(1, 1, 32'h10, 32'h0, SEL_WORD, 0, "rdwr_both");
    do_access(1, 0, 32'h11, 32'h0, 2'd3, 0, "sel_rsv");

    // Reset while we_n is low: strobes must drop on the next edge.
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 32'h320;
    bus_if.req_wdata = 32'hA5A5_5A5A;
    bus_if.req_sel   = SEL_WORD;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (!ram_we_n) hit = 1'b1;
      else @(posedge clk);
    end
    check("rstmid_pulse_seen", {31'h0, hit}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_stall_forced", {31'h0, bus_if.stall}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rstmid_strobes", {29'h0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    check("rstmid_data_oe", {31'h0, ram_data_oe}, 32'h0);
    check("rstmid_stall", {31'h0, bus_if.stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.req_write = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    model_rdata = 32'h0;

    do_access(0, 1, 32'h44, 32'hCAFE_F00D, SEL_WORD, 0, "b2b_st");
    do_access(1, 0, 32'h44, 32'h0, SEL_WORD, 0, "b2b_ld");
    check("b2b_ld_const", bus_if.rdata, 32'hCAFE_F00D);

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 9));
      a    = $urandom_range(0, 255);
      d    = $urandom;
      s    = 2'($urandom_range(0, 2));
      rd   = 1'($urandom_range(0, 1));
      if (kind == 9) s = 2'($urandom_range(0, 3));
      else if (s == SEL_WORD) a = a & 32'hFFFF_FFFC;
      else if (s == SEL_HALF) a = a & 32'hFFFF_FFFE;
      if (kind == 8) do_access(1, 1, a, d, s, 1'($urandom_range(0, 1)), "rnd_both");
      else           do_access(rd, !rd, a, d, s, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
